// File: rtl/sram_1r1w_clr_array.sv
// 1R1W masked SRAM array with a post-reset hardware clear sequencer.
// Build macro SRAM_RW_BYPASS_EN: same-address read/write returns write-merged data (write-first).
module sram_1r1w_clr_array #(
  parameter int DATA_WIDTH   = 36,
  parameter int DEPTH        = 128,
  parameter int MASK_GRAN    = 9,
  parameter int READ_LATENCY = 1,
  localparam int AW = $clog2(DEPTH),
  localparam int MW = DATA_WIDTH / MASK_GRAN
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  r_en,
  input  logic [AW-1:0]         r_addr,
  output logic                  r_valid,
  output logic [DATA_WIDTH-1:0] r_data,
  input  logic                  w_en,
  input  logic [AW-1:0]         w_addr,
  input  logic [MW-1:0]         w_mask,
  input  logic [DATA_WIDTH-1:0] w_data
);

  typedef enum logic {CLEAR, READY} state_e;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

  state_e                  state_q, state_d;
  logic [AW-1:0]           clr_cnt_q, clr_cnt_d;
  logic                    ready_q, ready_d;
  logic                    r_valid_q, r_valid_d;
  logic [DATA_WIDTH-1:0]   r_data_q, r_data_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    rd_in_range, wr_in_range;
  logic                    rd_accept, wr_accept;
  logic [DATA_WIDTH-1:0]   lane_mask, wr_old, wr_merged, rd_word;
  logic                    mem_we;
  logic [AW-1:0]           mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    pipe_valid;
  logic [DATA_WIDTH-1:0]   pipe_data;

  // Address qualification, lane merge and read word selection
  always_comb begin
    rd_in_range = ({1'b0, r_addr} < DEPTH_EXT);
    wr_in_range = ({1'b0, w_addr} < DEPTH_EXT);
    rd_accept   = ready_q & r_en;
    wr_accept   = ready_q & w_en & wr_in_range;

    lane_mask = '0;
    for (int unsigned i = 0; i < MW; i++) begin
      lane_mask[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{w_mask[i]}};
    end

    wr_old    = wr_in_range ? mem_q[w_addr] : '0;
    wr_merged = (wr_old & ~lane_mask) | (w_data & lane_mask);
    rd_word   = rd_in_range ? mem_q[r_addr] : '0;
`ifdef SRAM_RW_BYPASS_EN
    if (wr_accept && (w_addr == r_addr)) begin
      rd_word = wr_merged;
    end
`endif
  end

  // Clear sequencer owns the write port until every entry is zeroed
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    mem_we    = 1'b0;
    mem_waddr = w_addr;
    mem_wdata = wr_merged;
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = READY;
          ready_d   = 1'b1;
          clr_cnt_d = '0;
        end
      end
      READY: begin
        mem_we = wr_accept;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s1_valid_q, s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

    always_comb begin
      s1_valid_d = rd_accept;
      s1_data_d  = rd_accept ? rd_word : s1_data_q;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_data_q  <= s1_data_d;
      end
    end

    assign pipe_valid = s1_valid_q;
    assign pipe_data  = s1_data_q;
  end else begin : g_lat1
    assign pipe_valid = rd_accept;
    assign pipe_data  = rd_word;
  end

  // Output register holds the last read value between reads
  always_comb begin
    r_valid_d = pipe_valid;
    r_data_d  = pipe_valid ? pipe_data : r_data_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
    end
  end

  assign ready   = ready_q;
  assign r_valid = r_valid_q;
  assign r_data  = r_data_q;

endmodule
